cbd_sampler: RTL and testbench

Streaming centered-binomial-distribution sampler for the Kyber noise path, selectable at run time between η=2 and η=3. It accepts 32-bit words of PRF/SHAKE output through a valid/ready port, buffers the bits, and emits `LANES` coefficients per beat until one polynomial of `N` coefficients is complete. It sits between the SHAKE squeeze stage and the NTT/polynomial RAM writer.

---
 rtl/kyber_pkg.sv | 15 +
 rtl/cbd_lane.sv | 51 +++++
 rtl/cbd_sampler.sv | 181 ++++++++++++++++++
 tb/tb_cbd_sampler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and CBD sampler types.
// Used by cbd_sampler and cbd_lane.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int CBD_K_ETA2 = 4;
  localparam int CBD_K_ETA3 = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cbd_state_t;

endpackage

// File: rtl/cbd_lane.sv
// Combinational single-coefficient CBD unit for eta=2 (bits[3:0]) or eta=3 (bits[5:0]).
// CBD_MODQ_EN defined: output mapped into [0, Q-1]; otherwise sign-extended two's complement.
module cbd_lane
  import kyber_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int Q      = KYBER_Q
) (
  input  logic [5:0]        bits,
  input  logic              eta3,
  output logic [COEF_W-1:0] coef
);

  localparam logic [COEF_W-1:0] Q_C = COEF_W'(Q);

  logic [1:0]        a_s;
  logic [1:0]        b_s;
  logic [3:0]        c_s;
  logic [COEF_W-1:0] sext_s;

  // Half-sums of the coefficient's bit group.
  always_comb begin
    a_s = 2'b00;
    b_s = 2'b00;
    if (eta3) begin
      a_s = {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
      b_s = {1'b0, bits[3]} + {1'b0, bits[4]} + {1'b0, bits[5]};
    end else begin
      a_s = {1'b0, bits[0]} + {1'b0, bits[1]};
      b_s = {1'b0, bits[2]} + {1'b0, bits[3]};
    end
  end

  assign c_s    = {2'b00, a_s} - {2'b00, b_s};
  assign sext_s = {{(COEF_W-4){c_s[3]}}, c_s};

  // Adding Q to a negative value wraps it into [0, Q-1] modulo 2^COEF_W.
  always_comb begin
    coef = sext_s;
`ifdef CBD_MODQ_EN
    if (c_s[3]) begin
      coef = Q_C + sext_s;
    end else begin
      coef = sext_s;
    end
`else
    coef = sext_s;
`endif
  end

endmodule

// File: rtl/cbd_sampler.sv
// Streaming centered-binomial sampler (eta=2/3) turning PRF words into LANES coefficients per beat.
// CBD_MODQ_EN (passed to cbd_lane) selects mod-q output mapping instead of two's complement.
module cbd_sampler
  import kyber_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int LANES  = 4,
  parameter int N      = KYBER_N,
  parameter int Q      = KYBER_Q,
  parameter int COEF_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    eta3,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*COEF_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int BUF_W  = 2 * IN_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int WORDS2 = N * CBD_K_ETA2 / IN_W;
  localparam int WORDS3 = N * CBD_K_ETA3 / IN_W;
  localparam int WORD_W = $clog2(WORDS3 + 1);

  localparam logic [FILL_W-1:0] BPB2      = FILL_W'(LANES * CBD_K_ETA2);
  localparam logic [FILL_W-1:0] BPB3      = FILL_W'(LANES * CBD_K_ETA3);
  localparam logic [FILL_W-1:0] FILL_IN   = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] FILL_LIM  = FILL_W'(BUF_W - IN_W);
  localparam logic [WORD_W-1:0] WMAX2     = WORD_W'(WORDS2);
  localparam logic [WORD_W-1:0] WMAX3     = WORD_W'(WORDS3);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BEATS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  cbd_state_t             state_r, state_nxt_s;
  logic                   eta3_r, eta3_nxt_s;
  logic [FILL_W-1:0]      fill_r, fill_nxt_s, fill_keep_s;
  logic [WORD_W-1:0]      words_r, words_nxt_s;
  logic [BEAT_W-1:0]      beats_r, beats_nxt_s;
  logic [BUF_W-1:0]       buf_r, buf_nxt_s, buf_keep_s;
  logic                   in_ready_r, in_ready_nxt_s;
  logic                   out_valid_r;
  logic                   out_last_r;
  logic [LANES*COEF_W-1:0] out_data_r;
  logic [LANES*COEF_W-1:0] lanes_s;
  logic [FILL_W-1:0]      bpb_s;
  logic                   accept_s;
  logic                   load_s;
  logic                   last_hs_s;

  assign bpb_s     = eta3_r ? BPB3 : BPB2;
  assign accept_s  = in_valid && in_ready_r;
  assign load_s    = (state_r == ST_RUN) && (fill_r >= bpb_s) && (beats_r < BEAT_MAX) &&
                     (!out_valid_r || out_ready);
  assign last_hs_s = out_valid_r && out_ready && out_last_r;

  // A consume shifts the buffer down before any new word is appended on top.
  assign buf_keep_s  = load_s ? (buf_r >> bpb_s) : buf_r;
  assign fill_keep_s = load_s ? (fill_r - bpb_s) : fill_r;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [5:0] bits_s;
      assign bits_s = eta3_r ? buf_r[i*CBD_K_ETA3 +: 6] : {2'b00, buf_r[i*CBD_K_ETA2 +: 4]};
      cbd_lane #(
        .COEF_W (COEF_W),
        .Q      (Q)
      ) u_lane (
        .bits (bits_s),
        .eta3 (eta3_r),
        .coef (lanes_s[i*COEF_W +: COEF_W])
      );
    end
  endgenerate

  // Next-state for the FSM and the bit buffer bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    eta3_nxt_s  = eta3_r;
    fill_nxt_s  = fill_r;
    words_nxt_s = words_r;
    beats_nxt_s = beats_r;
    buf_nxt_s   = buf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          eta3_nxt_s  = eta3;
          fill_nxt_s  = {FILL_W{1'b0}};
          words_nxt_s = {WORD_W{1'b0}};
          beats_nxt_s = {BEAT_W{1'b0}};
          buf_nxt_s   = {BUF_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          buf_nxt_s   = buf_keep_s | ({{IN_W{1'b0}}, in_data} << fill_keep_s);
          fill_nxt_s  = fill_keep_s + FILL_IN;
          words_nxt_s = words_r + WORD_W'(1);
        end else begin
          buf_nxt_s   = buf_keep_s;
          fill_nxt_s  = fill_keep_s;
        end
        if (load_s) begin
          beats_nxt_s = beats_r + BEAT_W'(1);
        end else begin
          beats_nxt_s = beats_r;
        end
        if (last_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // in_ready is precomputed from the next state so it leaves a flop.
  always_comb begin
    in_ready_nxt_s = (state_nxt_s == ST_RUN) &&
                     (words_nxt_s < (eta3_nxt_s ? WMAX3 : WMAX2)) &&
                     (fill_nxt_s <= FILL_LIM);
  end

  // Control and buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      eta3_r     <= 1'b0;
      fill_r     <= {FILL_W{1'b0}};
      words_r    <= {WORD_W{1'b0}};
      beats_r    <= {BEAT_W{1'b0}};
      buf_r      <= {BUF_W{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      eta3_r     <= eta3_nxt_s;
      fill_r     <= fill_nxt_s;
      words_r    <= words_nxt_s;
      beats_r    <= beats_nxt_s;
      buf_r      <= buf_nxt_s;
      in_ready_r <= in_ready_nxt_s;
    end
  end

  // Output beat register; holds its contents while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(LANES*COEF_W){1'b0}};
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= lanes_s;
      out_last_r  <= (beats_r == BEAT_LAST);
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r == ST_RUN);

endmodule

// File: tb/tb_cbd_sampler.sv
// Randomized self-checking bench for cbd_sampler against a bit-stream CBD reference model.
module tb_cbd_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        eta3;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_last;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;

  bit          bitq [0:2047];
  int          nbits;
  int          beats_seen;
  int          words_acc;
  int          widx;
  logic [31:0] wq [0:63];
  logic [47:0] first_beat;
  logic [47:0] second_beat;
  logic [11:0] exp_l0;

  cbd_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .eta3      (eta3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: coefficient j of the polynomial uses stream bits [j*k +: k].
  function automatic logic [47:0] model_beat(input int beat, input bit e3);
    int k, h, a, b, c, base;
    logic [47:0] r;
    r = 48'd0;
    k = e3 ? 6 : 4;
    h = k / 2;
    for (int l = 0; l < 4; l++) begin
      base = (beat * 4 + l) * k;
      a = 0;
      b = 0;
      for (int j = 0; j < h; j++) begin
        a += int'(bitq[base + j]);
        b += int'(bitq[base + h + j]);
      end
      c = a - b;
`ifdef CBD_MODQ_EN
      if (c < 0) c += 3329;
`endif
      r[l*12 +: 12] = 12'(c);
    end
    return r;
  endfunction

  task automatic fill_words(input bit zeros);
    for (int i = 0; i < 64; i++) wq[i] = zeros ? 32'd0 : $urandom;
  endtask

  task automatic run_poly(input bit e3, input int rdy_pct, input bit do_stall, input int abort_beats);
    int bpb, wmax, fill_m, cyc, stall_left, lasts;
    bit done, aborted, stalled, saw_block, exp_rdy;
    bpb = e3 ? 24 : 16;
    wmax = e3 ? 48 : 32;
    nbits = 0; beats_seen = 0; words_acc = 0; widx = 0; lasts = 0;
    stall_left = 0; stalled = 0; saw_block = 0; done = 0; aborted = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0; eta3 = e3; start = 1'b1;
    @(negedge clk);
    chk("idle_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    eta3 = ~e3;
    while (!done && cyc < 3000) begin
      in_data = wq[widx % 64];
      if (stall_left > 0) begin
        in_valid = 1'b1;
        out_ready = 1'b0;
        stall_left--;
      end else begin
        in_valid = (int'($urandom_range(0, 99)) < 75);
        out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      end
      @(negedge clk);
      fill_m = nbits - (beats_seen + int'(out_valid)) * bpb;
      exp_rdy = busy && (words_acc < wmax) && (fill_m <= 32);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      chk("busy_run", {63'd0, busy}, 64'd1);
      if (stalled && !out_ready && !in_ready) saw_block = 1'b1;
      if (out_valid) begin
        chk("bits_avail", {63'd0, (nbits >= (beats_seen + 1) * bpb)}, 64'd1);
        chk("out_data", {16'd0, out_data}, {16'd0, model_beat(beats_seen, e3)});
        chk("out_last", {63'd0, out_last}, {63'd0, (beats_seen == 63)});
      end
      if (in_valid && in_ready) begin
        for (int j = 0; j < 32; j++) if (nbits + j < 2048) bitq[nbits + j] = in_data[j];
        nbits += 32;
        words_acc++;
        widx++;
      end
      if (out_valid && out_ready) begin
        if (beats_seen == 0) first_beat = out_data;
        if (beats_seen == 1) second_beat = out_data;
        if (out_last) lasts++;
        beats_seen++;
        if (beats_seen == 64) done = 1'b1;
        if (do_stall && !stalled && beats_seen == 20) begin
          stalled = 1'b1;
          stall_left = 10;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_beats > 0 && beats_seen >= abort_beats && !done) begin
        aborted = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("timeout", 64'd0, 64'd1);
    end else if (aborted) begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {16'd0, out_data}, 64'd0);
      chk("rst_out_last", {63'd0, out_last}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      chk("busy_end", {63'd0, busy}, 64'd0);
      chk("valid_end", {63'd0, out_valid}, 64'd0);
      chk("words", 64'(words_acc), 64'(wmax));
      chk("beats", 64'(beats_seen), 64'd64);
      chk("last_count", 64'(lasts), 64'd1);
      if (do_stall) chk("stall_block", {63'd0, saw_block}, 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eta3 = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {16'd0, out_data}, 64'd0);
    chk("reset_out_last", {63'd0, out_last}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_words(1'b0);
    wq[0] = 32'h0000_0003;
    run_poly(1'b0, 70, 1'b0, 0);
    chk("eta2_w3_beat0", {16'd0, first_beat}, 64'h0000_0000_0000_0002);
    chk("eta2_w3_beat1", {16'd0, second_beat}, 64'd0);

`ifdef CBD_MODQ_EN
    exp_l0 = 12'd3327;
`else
    exp_l0 = 12'hFFE;
`endif
    fill_words(1'b0);
    wq[0] = 32'h0000_000C;
    run_poly(1'b0, 100, 1'b1, 0);
    chk("eta2_wC_lane0", {52'd0, first_beat[11:0]}, {52'd0, exp_l0});

    fill_words(1'b0);
    wq[0] = 32'h0000_0007;
    run_poly(1'b1, 100, 1'b0, 0);
    chk("eta3_w7_lane0", {52'd0, first_beat[11:0]}, 64'd3);

`ifdef CBD_MODQ_EN
    exp_l0 = 12'd3326;
`else
    exp_l0 = 12'hFFD;
`endif
    fill_words(1'b0);
    wq[0] = 32'h0000_0038;
    run_poly(1'b1, 60, 1'b1, 0);
    chk("eta3_w38_lane0", {52'd0, first_beat[11:0]}, {52'd0, exp_l0});

    fill_words(1'b0);
    run_poly(1'b0, 80, 1'b0, 20);

    fill_words(1'b1);
    run_poly(1'b0, 90, 1'b0, 0);
    chk("zero_beat0", {16'd0, first_beat}, 64'd0);

    for (int r = 0; r < 3; r++) begin
      fill_words(1'b0);
      run_poly(r[0], 40 + 25 * r, r[1], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
